// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_types: shared fetch-stage types and constants
package instruction_fetch_types;
   typedef logic [63:0] double_word;
   typedef enum logic [1:0] {S_REQ, S_WAIT, S_FLUSH} fetch_state_e;
   localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_hold_buffer.sv
// fetch_hold_buffer: one-entry holding slot for a response that arrives while decode stalls
module fetch_hold_buffer (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        drain,
   input  logic        clear,
   input  logic [31:0] instr_in,
   input  logic [63:0] pc_in,
   output logic        valid,
   output logic [31:0] instr,
   output logic [63:0] pc
);
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= instr_in;
         pc    <= pc_in;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC generation, one-at-a-time imem requests, stall hold and branch flush
module instruction_fetch
   import instruction_fetch_types::*;
#(
   parameter double_word RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        stall_in,
   input  logic        branch_reset,
   input  logic [63:0] branch_target,
   output logic        pc_output_valid,
   output logic [31:0] instruction,
   output logic [63:0] instruction_pc
);
   fetch_state_e state, next_state;
   double_word   pc, req_pc, buf_pc;
   logic [31:0]  buf_instr;
   logic         buf_valid, req_fire, resp_take, in_flight;
   assign imem_req_valid = state == S_REQ && !buf_valid && !rst;
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign resp_take      = state == S_WAIT && imem_resp_valid && !branch_reset;
   assign in_flight      = req_fire || (state != S_REQ && !imem_resp_valid);
   always_comb begin
      next_state = state;
      next_state = branch_reset ? (in_flight ? S_FLUSH : S_REQ) :
                   state == S_REQ ? (req_fire ? S_WAIT : S_REQ) :
                   imem_resp_valid ? S_REQ : state;
   end
   always_ff @(posedge clk) begin
      if (rst) state <= S_REQ;
      else     state <= next_state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pc              <= RESET_PC;
         req_pc          <= '0;
         pc_output_valid <= 1'b0;
         instruction     <= '0;
         instruction_pc  <= '0;
      end else begin
         if (req_fire) req_pc <= pc;
         if (branch_reset) begin
            pc              <= branch_target & ~double_word'(3);
            pc_output_valid <= 1'b0;
         end else begin
            if (resp_take) pc <= pc + double_word'(INSTR_BYTES);
            if (!stall_in) begin
               pc_output_valid <= buf_valid || resp_take;
               instruction     <= buf_valid ? buf_instr : resp_take ? imem_resp_data : instruction;
               instruction_pc  <= buf_valid ? buf_pc : resp_take ? req_pc : instruction_pc;
            end
         end
      end
   end
   fetch_hold_buffer u_hold (
      .clk      (clk),
      .rst      (rst),
      .load     (resp_take && stall_in),
      .drain    (buf_valid && !stall_in),
      .clear    (branch_reset),
      .instr_in (imem_resp_data),
      .pc_in    (req_pc),
      .valid    (buf_valid),
      .instr    (buf_instr),
      .pc       (buf_pc)
   );
endmodule
